maple_pattern_encoder: RTL

- Next-generation Maple bus framing encoder: one block generates both the start-of-frame and the end-of-frame pattern on SDCKA/SDCKB.
- Adds over the previous encoder: mode selection, runtime pulse-count override, parametrised phase width, and a start/busy/done handshake.
- Sits between the packet transmitter FSM and the bit serialiser, which shares the line drivers through an external mux.

---
 rtl/maple_pattern_encoder_pkg.sv | 22 ++
 rtl/maple_pattern_encoder_if.sv | 28 ++
 rtl/maple_pattern_encoder_phase_timer.sv | 26 ++
 rtl/maple_pattern_encoder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/maple_pattern_encoder_pkg.sv
// maple_pkg: shared definitions for the Maple bus framing blocks.
//   state_t          one-hot encoder state (6 states)
//   MODE_START/END   values of the mode input
//   DEF_*_PULSES     default pulse counts, shared with serialiser/decoder
package maple_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_SETUP  = 6'b000010,
        ST_LEAD   = 6'b000100,
        ST_TOGGLE = 6'b001000,
        ST_TAIL   = 6'b010000,
        ST_DONE   = 6'b100000
    } state_t;

    localparam logic MODE_START = 1'b0;
    localparam logic MODE_END   = 1'b1;

    localparam int DEF_START_PULSES = 4;
    localparam int DEF_END_PULSES   = 2;

endpackage

// File: rtl/maple_pattern_encoder_if.sv
// Handshake and line bundle of maple_pattern_encoder.
//   master: start, mode, pulses out; busy, done, sdcka, sdckb in
//   slave : the encoder side (directions reversed)
// Optional macro MAPLE_PATTERN_OE_EN adds sdck_oe (encoder output).
interface maple_pattern_encoder_if #(parameter int CNT_W = 8);

    logic             start;
    logic             mode;
    logic [CNT_W-1:0] pulses;
    logic             busy;
    logic             done;
    logic             sdcka;
    logic             sdckb;
`ifdef MAPLE_PATTERN_OE_EN
    logic             sdck_oe;

    modport master (output start, mode, pulses,
                    input  busy, done, sdcka, sdckb, sdck_oe);
    modport slave  (input  start, mode, pulses,
                    output busy, done, sdcka, sdckb, sdck_oe);
`else
    modport master (output start, mode, pulses,
                    input  busy, done, sdcka, sdckb);
    modport slave  (input  start, mode, pulses,
                    output busy, done, sdcka, sdckb);
`endif

endinterface

// File: rtl/maple_pattern_encoder_phase_timer.sv
// maple_phase_timer: divides clk into pattern phases.
//   clk, reset (async, active-low), clear (hold counter at zero)
//   tick: high for one cycle every PHASE_CLKS cycles while clear is low
module maple_phase_timer #(
    parameter int PHASE_CLKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt_q;

    assign tick = !clear && (cnt_q == 8'(PHASE_CLKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (clear || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 8'd1;
    end

endmodule

// File: rtl/maple_pattern_encoder.sv
// maple_pattern_encoder: generates the Maple start-of-frame (mode 0) or
// end-of-frame (mode 1) pattern on sdcka/sdckb.
//   clk, reset (async, active-low)
//   bus.slave: start/mode/pulses in; busy, done, sdcka, sdckb out
// Optional macro MAPLE_PATTERN_OE_EN: adds bus.sdck_oe, high SETUP..TAIL.
// All outputs are registered from the next-state values, so they line
// up exactly with the state register.
module maple_pattern_encoder
    import maple_pkg::*;
#(
    parameter int PHASE_CLKS   = 2,
    parameter int CNT_W        = 8,
    parameter int START_PULSES = DEF_START_PULSES,
    parameter int END_PULSES   = DEF_END_PULSES
) (
    input  logic                   clk,
    input  logic                   reset,
    maple_pattern_encoder_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             lvl_q, lvl_d;   // TOGGLE sub-phase: 0 = low, 1 = high
    logic             mode_q, mode_d;
    logic             sdcka_q, sdcka_d, sdckb_q, sdckb_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             held_v, pulse_v;
    logic             tick, clear;

    assign clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

    maple_phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        lvl_d   = lvl_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d = ST_SETUP;
                mode_d  = bus.mode;
                cnt_d   = '0;
                lvl_d   = 1'b0;
                if (bus.pulses != '0)
                    n_d = bus.pulses;
                else if (bus.mode == MODE_END)
                    n_d = CNT_W'(END_PULSES);
                else
                    n_d = CNT_W'(START_PULSES);
            end
            ST_SETUP: if (tick) state_d = ST_LEAD;
            ST_LEAD: if (tick) begin
                state_d = ST_TOGGLE;
                lvl_d   = 1'b0;
                cnt_d   = '0;
            end
            ST_TOGGLE: if (tick) begin
                // cnt_q counts completed high phases
                if (!lvl_q)
                    lvl_d = 1'b1;
                else if (cnt_q == n_q - CNT_W'(1))
                    state_d = ST_TAIL;
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    lvl_d = 1'b0;
                end
            end
            ST_TAIL: if (tick) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // held = line parked low from LEAD to TOGGLE; pulse = toggling line
        held_v  = 1'b1;
        pulse_v = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            ST_SETUP:  busy_d = 1'b1;
            ST_LEAD: begin
                busy_d = 1'b1;
                held_v = 1'b0;
            end
            ST_TOGGLE: begin
                busy_d  = 1'b1;
                held_v  = 1'b0;
                pulse_v = lvl_d;
            end
            ST_TAIL:   busy_d = 1'b1;
            ST_DONE:   done_d = 1'b1;
            default: ;
        endcase
        sdcka_d = (mode_d == MODE_START) ? held_v : pulse_v;
        sdckb_d = (mode_d == MODE_START) ? pulse_v : held_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            lvl_q   <= 1'b0;
            mode_q  <= MODE_START;
            sdcka_q <= 1'b1;
            sdckb_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            lvl_q   <= lvl_d;
            mode_q  <= mode_d;
            sdcka_q <= sdcka_d;
            sdckb_q <= sdckb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sdcka = sdcka_q;
    assign bus.sdckb = sdckb_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

`ifdef MAPLE_PATTERN_OE_EN
    logic oe_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            oe_q <= 1'b0;
        else
            oe_q <= busy_d;
    end
    assign bus.sdck_oe = oe_q;
`endif

endmodule
